// File: rtl/multi_stop_filter.sv
// multi_stop_filter
//   Multi-channel stop-hit filter for the TDC. Each of NCH asynchronous stop lines is
//   synchronised into clk, rising-edge detected, and passed through a per-channel dead-time
//   FSM (IDLE -> HOLD -> WAIT_LOW). Accepted edges give a one-cycle filtered_hit pulse.
//   Edges that arrive during HOLD give a one-cycle pileup pulse instead. valid/hit_mask
//   follow filtered_hit by one cycle.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   hit          [NCH] raw asynchronous stop hits
//   enable       synchronous enable; low forces all channels idle
//   dead_time    [DTW] hold-off length, sampled on entry to HOLD
//   count_clr    synchronous clear of hit counters
//   filtered_hit [NCH] one-cycle pulse per accepted edge
//   pileup       [NCH] one-cycle pulse per edge rejected during HOLD
//   valid        one-cycle strobe, one cycle after any filtered_hit bit
//   hit_mask     [NCH] filtered_hit registered alongside valid
//   hit_count    [NCH*CNTW] per-channel saturating counters, channel i at [i*CNTW +: CNTW]
//
// Optional feature: define MULTI_STOP_FILTER_HIT_COUNT_EN to build the hit counters.
// Without it hit_count is tied to zero and count_clr is ignored.

module multi_stop_filter #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned NSYNC = 2,
    parameter int unsigned DTW   = 8,
    parameter int unsigned CNTW  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NCH-1:0]      hit,
    input  logic                enable,
    input  logic [DTW-1:0]      dead_time,
    input  logic                count_clr,
    output logic [NCH-1:0]      filtered_hit,
    output logic [NCH-1:0]      pileup,
    output logic                valid,
    output logic [NCH-1:0]      hit_mask,
    output logic [NCH*CNTW-1:0] hit_count
);

    typedef enum logic [1:0] {StIdle, StHold, StWaitLow} state_e;

    logic [NCH-1:0][NSYNC-1:0] sync_q;
    logic [NCH-1:0]            s_last;
    logic [NCH-1:0]            s_d_q;
    logic [NCH-1:0]            rise;

    state_e                    state_q [NCH];
    state_e                    state_d [NCH];
    logic [NCH-1:0][DTW-1:0]   dcnt_q;
    logic [NCH-1:0][DTW-1:0]   dcnt_d;

    logic [NCH-1:0]            fh_d, fh_q;
    logic [NCH-1:0]            pu_d, pu_q;
    logic                      valid_q;
    logic [NCH-1:0]            mask_q;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            s_last[i] = sync_q[i][NSYNC-1];
        end
    end

    // s_d_q tracks the synchronised level regardless of enable, so a line already high
    // when enable rises never looks like a fresh edge.
    assign rise = s_last & ~s_d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            s_d_q  <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                sync_q[i] <= {sync_q[i][NSYNC-2:0], hit[i]};
            end
            s_d_q <= s_last;
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            dcnt_d[i]  = dcnt_q[i];
            fh_d[i]    = 1'b0;
            pu_d[i]    = 1'b0;
            if (!enable) begin
                // Abort any hold silently; no pileup is reported.
                state_d[i] = StIdle;
                dcnt_d[i]  = '0;
            end else begin
                unique case (state_q[i])
                    StIdle: begin
                        if (rise[i]) begin
                            state_d[i] = StHold;
                            dcnt_d[i]  = dead_time;
                            fh_d[i]    = 1'b1;
                        end
                    end
                    StHold: begin
                        pu_d[i] = rise[i];
                        if (dcnt_q[i] == '0) begin
                            state_d[i] = s_last[i] ? StWaitLow : StIdle;
                        end else begin
                            dcnt_d[i] = dcnt_q[i] - DTW'(1);
                        end
                    end
                    StWaitLow: begin
                        if (!s_last[i]) begin
                            state_d[i] = StIdle;
                        end
                    end
                    default: begin
                        state_d[i] = StIdle;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= StIdle;
            end
            dcnt_q  <= '0;
            fh_q    <= '0;
            pu_q    <= '0;
            valid_q <= 1'b0;
            mask_q  <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
            end
            dcnt_q  <= dcnt_d;
            fh_q    <= fh_d;
            pu_q    <= pu_d;
            valid_q <= |fh_q;
            mask_q  <= fh_q;
        end
    end

    assign filtered_hit = fh_q;
    assign pileup       = pu_q;
    assign valid        = valid_q;
    assign hit_mask     = mask_q;

`ifdef MULTI_STOP_FILTER_HIT_COUNT_EN
    logic [NCH-1:0][CNTW-1:0] cnt_q;

    // Counters advance from the registered pulse; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (count_clr) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (fh_q[i] && (cnt_q[i] != {CNTW{1'b1}})) begin
                    cnt_q[i] <= cnt_q[i] + CNTW'(1);
                end
            end
        end
    end

    assign hit_count = cnt_q;
`else
    logic unused_count_clr;
    assign unused_count_clr = count_clr;
    assign hit_count        = '0;
`endif

endmodule

// File: tb/tb_multi_stop_filter.sv
module tb_multi_stop_filter;

    localparam int NCH   = 4;
    localparam int NSYNC = 2;
    localparam int DTW   = 8;
    localparam int CNTW  = 4;
    localparam int HMAX  = 8192;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NCH-1:0]      hit;
    logic                enable;
    logic [DTW-1:0]      dead_time;
    logic                count_clr;
    logic [NCH-1:0]      filtered_hit;
    logic [NCH-1:0]      pileup;
    logic                valid;
    logic [NCH-1:0]      hit_mask;
    logic [NCH*CNTW-1:0] hit_count;

    multi_stop_filter #(
        .NCH   (NCH),
        .NSYNC (NSYNC),
        .DTW   (DTW),
        .CNTW  (CNTW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hit          (hit),
        .enable       (enable),
        .dead_time    (dead_time),
        .count_clr    (count_clr),
        .filtered_hit (filtered_hit),
        .pileup       (pileup),
        .valid        (valid),
        .hit_mask     (hit_mask),
        .hit_count    (hit_count)
    );

    always #5 clk = ~clk;

    // Reference model: hist[e] is the hit value sampled at edge e. An edge is accepted when
    // enabled and later than the end of the previous acceptance window.
    logic [NCH-1:0] hist [HMAX];
    int             e;
    int             hold_end [NCH];
    int             cnt [NCH];
    logic [NCH-1:0] fh_exp, pu_exp, fh_prev, mask_exp;
    logic           valid_exp;
    int             checks = 0;
    int             errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp, e);
        end
    endtask

    task automatic check_all();
        logic [NCH*CNTW-1:0] cexp;
        cexp = '0;
`ifdef MULTI_STOP_FILTER_HIT_COUNT_EN
        for (int i = 0; i < NCH; i++) cexp[i*CNTW +: CNTW] = CNTW'(cnt[i]);
`endif
        chk("filtered_hit", 32'(filtered_hit), 32'(fh_exp));
        chk("pileup", 32'(pileup), 32'(pu_exp));
        chk("valid", 32'(valid), 32'(valid_exp));
        chk("hit_mask", 32'(hit_mask), 32'(mask_exp));
        chk("hit_count", 32'(hit_count), 32'(cexp));
    endtask

    task automatic model_reset();
        for (int k = e - NSYNC - 1; k <= e; k++) hist[k] = '0;
        for (int i = 0; i < NCH; i++) begin
            hold_end[i] = -1;
            cnt[i]      = 0;
        end
        fh_exp    = '0;
        pu_exp    = '0;
        fh_prev   = '0;
        mask_exp  = '0;
        valid_exp = 1'b0;
    endtask

    task automatic do_edge(input logic [NCH-1:0] h, input logic en, input int dt,
                           input logic clr);
        logic r;
        @(negedge clk);
        hit       = h;
        enable    = en;
        dead_time = DTW'(dt);
        count_clr = clr;
        @(posedge clk);
        e++;
        if (!rst_n) begin
            model_reset();
        end else begin
            hist[e]   = h;
            valid_exp = |fh_prev;
            mask_exp  = fh_prev;
            for (int i = 0; i < NCH; i++) begin
                if (clr) cnt[i] = 0;
                else if (fh_prev[i] && cnt[i] < (1 << CNTW) - 1) cnt[i]++;
            end
            for (int i = 0; i < NCH; i++) begin
                r         = hist[e-NSYNC][i] & ~hist[e-NSYNC-1][i];
                fh_exp[i] = 1'b0;
                pu_exp[i] = 1'b0;
                if (!en) begin
                    hold_end[i] = -1;
                end else if (r) begin
                    if (e <= hold_end[i]) begin
                        pu_exp[i] = 1'b1;
                    end else begin
                        fh_exp[i]   = 1'b1;
                        hold_end[i] = e + dt + 1;
                    end
                end
            end
            fh_prev = fh_exp;
        end
        #1;
        check_all();
    endtask

    initial begin
        for (int k = 0; k < HMAX; k++) hist[k] = '0;
        e         = NSYNC + 2;
        rst_n     = 1'b0;
        hit       = '0;
        enable    = 1'b0;
        dead_time = '0;
        count_clr = 1'b0;
        model_reset();

        // Reset state
        repeat (3) do_edge(4'b0000, 1'b0, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) do_edge(4'b0000, 1'b1, 3, 1'b0);

        // Single hit on ch0, 5 cycles wide, dead_time 3
        repeat (5) do_edge(4'b0001, 1'b1, 3, 1'b0);
        repeat (8) do_edge(4'b0000, 1'b1, 3, 1'b0);

        // Retrigger within dead time on ch1, then a later accepted pulse
        do_edge(4'b0010, 1'b1, 10, 1'b0);
        repeat (3) do_edge(4'b0000, 1'b1, 10, 1'b0);
        do_edge(4'b0010, 1'b1, 10, 1'b0);
        repeat (15) do_edge(4'b0000, 1'b1, 10, 1'b0);
        do_edge(4'b0010, 1'b1, 10, 1'b0);
        repeat (14) do_edge(4'b0000, 1'b1, 10, 1'b0);

        // Simultaneous edges
        repeat (2) do_edge(4'b1010, 1'b1, 2, 1'b0);
        repeat (6) do_edge(4'b0000, 1'b1, 2, 1'b0);

        // Enable rises mid-pulse on ch2: no output expected
        repeat (3) do_edge(4'b0100, 1'b0, 2, 1'b0);
        repeat (4) do_edge(4'b0100, 1'b1, 2, 1'b0);
        repeat (3) do_edge(4'b0000, 1'b1, 2, 1'b0);
        // Enable drops during HOLD, then the next edge is accepted at once
        do_edge(4'b0100, 1'b1, 20, 1'b0);
        repeat (3) do_edge(4'b0000, 1'b1, 20, 1'b0);
        do_edge(4'b0000, 1'b0, 20, 1'b0);
        do_edge(4'b0100, 1'b1, 20, 1'b0);
        repeat (4) do_edge(4'b0000, 1'b1, 20, 1'b0);

        // Async reset mid-HOLD
        do_edge(4'b0001, 1'b1, 20, 1'b0);
        repeat (4) do_edge(4'b0000, 1'b1, 20, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (2) do_edge(4'b0000, 1'b1, 20, 1'b0);
        rst_n = 1'b1;
        do_edge(4'b0001, 1'b1, 2, 1'b0);
        repeat (5) do_edge(4'b0000, 1'b1, 2, 1'b0);

        // 17 accepted hits on ch3 (counter saturation), then clear coinciding with a pulse
        for (int n = 0; n < 17; n++) begin
            do_edge(4'b1000, 1'b1, 0, 1'b0);
            do_edge(4'b0000, 1'b1, 0, 1'b0);
        end
        repeat (4) do_edge(4'b0000, 1'b1, 0, 1'b0);
        do_edge(4'b1000, 1'b1, 0, 1'b0);
        do_edge(4'b0000, 1'b1, 0, 1'b0);
        do_edge(4'b0000, 1'b1, 0, 1'b0);
        do_edge(4'b0000, 1'b1, 0, 1'b1);
        repeat (3) do_edge(4'b0000, 1'b1, 0, 1'b0);

        // Randomised traffic
        begin
            int dt;
            dt = 3;
            for (int n = 0; n < 1500; n++) begin
                if ($urandom_range(0, 49) == 0) dt = $urandom_range(0, 7);
                do_edge(NCH'($urandom), ($urandom_range(0, 19) != 0), dt,
                        ($urandom_range(0, 49) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
